// File: rtl/bus_regfile_slave.sv
// ---------------------------------------------------------------------------
// bus_regfile_slave
//   Small register file behind a simple rd/wr request bus. Writes complete
//   in the accept cycle with per-byte enables. Reads take RD_WAIT wait states
//   and then present one response cycle. Accesses with addr >= NUM_REGS
//   touch no register and raise err for one cycle.
//
// Ports
//   clk     in   rising-edge clock
//   rstn    in   asynchronous active-low reset
//   rd      in   read request
//   wr      in   write request (wins over rd when both are set)
//   addr    in   [ADDR_W-1:0]   register index
//   din     in   [DATA_W-1:0]   write data
//   be      in   [DATA_W/8-1:0] byte enables; be[i] gates din[8i+7:8i]
//   ready   out  a request is accepted on this cycle's rising edge
//   dout    out  [DATA_W-1:0]   read data, held between read responses
//   rvalid  out  dout carries a read response this cycle
//   err     out  the current response targeted an out-of-range address
// ---------------------------------------------------------------------------
module bus_regfile_slave #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 8,
  parameter int RD_WAIT  = 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                rd,
  input  logic                wr,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   din,
  input  logic [DATA_W/8-1:0] be,
  output logic                ready,
  output logic [DATA_W-1:0]   dout,
  output logic                rvalid,
  output logic                err
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [DATA_W-1:0]   r_dout;
  logic                r_err;

  logic                w_accept_wr;
  logic                w_accept_rd;
  logic [ADDR_W-1:0]   w_rd_idx;
  logic                w_rd_in_range;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return int'(a) < NUM_REGS;
  endfunction

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking (<=) so every flop samples
      // the pre-edge values; blocking here would create order-dependent races.
      r_state <= w_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next-state and handshake outputs
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_next      = r_state;
    ready       = 1'b0;
    rvalid      = 1'b0;
    w_accept_wr = 1'b0;
    w_accept_rd = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        ready       = 1'b1;
        w_accept_wr = wr;
        // A simultaneous rd+wr is served as a write only.
        w_accept_rd = rd & ~wr;
        if (w_accept_rd) begin
          w_next = (RD_WAIT > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        // Counter holds the number of wait cycles still to run, this one included.
        if (r_cnt <= 4'd1) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        rvalid = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // On a zero-wait read the response is loaded at the accept edge itself,
  // so the live address is used; otherwise the captured one.
  assign w_rd_idx      = (r_state == S_IDLE) ? addr : r_addr;
  assign w_rd_in_range = in_range(w_rd_idx);

  // -------------------------------------------------------------------------
  // Register file, wait counter and response datapath
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: the register file is architecturally visible after reset, so
      // every entry is cleared here rather than left as uninitialised RAM.
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_cnt  <= '0;
      r_addr <= '0;
      r_dout <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= 1'b0;

      if (w_accept_wr) begin
        if (in_range(addr)) begin
          for (int j = 0; j < BE_W; j++) begin
            if (be[j]) begin
              r_regs[addr][8*j +: 8] <= din[8*j +: 8];
            end
          end
        end else begin
          r_err <= 1'b1;
        end
      end

      if (w_accept_rd) begin
        r_addr <= addr;
        r_cnt  <= 4'(RD_WAIT);
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end

      // dout and the read error only change on entry to RESP.
      if (w_next == S_RESP) begin
        r_dout <= w_rd_in_range ? r_regs[w_rd_idx] : '0;
        r_err  <= ~w_rd_in_range;
      end
    end
  end

  assign dout = r_dout;
  assign err  = r_err;

endmodule

// File: tb/tb_bus_regfile_slave.sv
// ---------------------------------------------------------------------------
// tb_bus_regfile_slave
//   Three instances cover the parameter points of interest:
//     [0] NUM_REGS=8, RD_WAIT=1   [1] NUM_REGS=5, RD_WAIT=3
//     [2] NUM_REGS=8, RD_WAIT=0
//   A plain array model holds the expected register contents; each transaction
//   task predicts the cycle-by-cycle handshake from RD_WAIT directly.
//   Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_bus_regfile_slave;

  localparam int N       = 3;
  localparam int NR [N]  = '{8, 5, 8};
  localparam int RW [N]  = '{1, 3, 0};

  logic        clk;
  logic        rstn   [N];
  logic        rd     [N];
  logic        wr     [N];
  logic [2:0]  addr   [N];
  logic [31:0] din    [N];
  logic [3:0]  be     [N];
  logic        ready  [N];
  logic [31:0] dout   [N];
  logic        rvalid [N];
  logic        err    [N];

  logic [31:0] m_regs [N][8];
  logic [31:0] m_dout [N];

  int n_cmp = 0;
  int n_err = 0;

  bus_regfile_slave #(.DATA_W(32), .ADDR_W(3), .NUM_REGS(8), .RD_WAIT(1)) u_dut0 (
    .clk(clk), .rstn(rstn[0]), .rd(rd[0]), .wr(wr[0]), .addr(addr[0]), .din(din[0]),
    .be(be[0]), .ready(ready[0]), .dout(dout[0]), .rvalid(rvalid[0]), .err(err[0]));

  bus_regfile_slave #(.DATA_W(32), .ADDR_W(3), .NUM_REGS(5), .RD_WAIT(3)) u_dut1 (
    .clk(clk), .rstn(rstn[1]), .rd(rd[1]), .wr(wr[1]), .addr(addr[1]), .din(din[1]),
    .be(be[1]), .ready(ready[1]), .dout(dout[1]), .rvalid(rvalid[1]), .err(err[1]));

  bus_regfile_slave #(.DATA_W(32), .ADDR_W(3), .NUM_REGS(8), .RD_WAIT(0)) u_dut2 (
    .clk(clk), .rstn(rstn[2]), .rd(rd[2]), .wr(wr[2]), .addr(addr[2]), .din(din[2]),
    .be(be[2]), .ready(ready[2]), .dout(dout[2]), .rvalid(rvalid[2]), .err(err[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_model(input int k);
    for (int a = 0; a < 8; a++) m_regs[k][a] = '0;
    m_dout[k] = '0;
  endtask

  task automatic drive_idle(input int k);
    rd[k]   = 1'b0;
    wr[k]   = 1'b0;
    addr[k] = '0;
    din[k]  = '0;
    be[k]   = '0;
  endtask

  // Called just after a falling edge; returns just after a falling edge.
  task automatic do_write(input int k, input logic [2:0] a, input logic [31:0] d,
                          input logic [3:0] b, input logic also_rd);
    check($sformatf("wr%0d_ready_before", k), ready[k], 1'b1);
    rd[k] = also_rd; wr[k] = 1'b1; addr[k] = a; din[k] = d; be[k] = b;
    @(negedge clk);
    if (int'(a) < NR[k]) begin
      for (int j = 0; j < 4; j++)
        if (b[j]) m_regs[k][a][8*j +: 8] = d[8*j +: 8];
    end
    check($sformatf("wr%0d_err", k),    err[k],    int'(a) >= NR[k]);
    check($sformatf("wr%0d_rvalid", k), rvalid[k], 1'b0);
    check($sformatf("wr%0d_ready", k),  ready[k],  1'b1);
    drive_idle(k);
    @(negedge clk);
    check($sformatf("wr%0d_err_clear", k), err[k],    1'b0);
    check($sformatf("wr%0d_no_resp", k),   rvalid[k], 1'b0);
  endtask

  // Called just after a falling edge; returns just after a falling edge.
  // Junk requests are driven throughout WAIT/RESP and must be ignored.
  task automatic do_read(input int k, input logic [2:0] a);
    logic [31:0] exp_d;
    logic        exp_e;
    exp_e = int'(a) >= NR[k];
    exp_d = exp_e ? 32'h0 : m_regs[k][a];
    check($sformatf("rd%0d_ready_before", k), ready[k], 1'b1);
    rd[k] = 1'b1; wr[k] = 1'b0; addr[k] = a; din[k] = $urandom; be[k] = 4'hF;
    for (int i = 1; i <= RW[k] + 1; i++) begin
      @(negedge clk);
      if (i <= RW[k]) begin
        check($sformatf("rd%0d_wait_ready", k),  ready[k],  1'b0);
        check($sformatf("rd%0d_wait_rvalid", k), rvalid[k], 1'b0);
        check($sformatf("rd%0d_wait_err", k),    err[k],    1'b0);
        check($sformatf("rd%0d_wait_dout", k),   dout[k],   m_dout[k]);
      end else begin
        check($sformatf("rd%0d_resp_rvalid", k), rvalid[k], 1'b1);
        check($sformatf("rd%0d_resp_ready", k),  ready[k],  1'b0);
        check($sformatf("rd%0d_resp_dout", k),   dout[k],   exp_d);
        check($sformatf("rd%0d_resp_err", k),    err[k],    exp_e);
      end
      rd[k]   = 1'($urandom_range(0, 1));
      wr[k]   = 1'b1;
      addr[k] = 3'($urandom);
      din[k]  = $urandom;
      be[k]   = 4'($urandom);
    end
    m_dout[k] = exp_d;
    @(negedge clk);
    drive_idle(k);
    check($sformatf("rd%0d_after_ready", k),  ready[k],  1'b1);
    check($sformatf("rd%0d_after_rvalid", k), rvalid[k], 1'b0);
    check($sformatf("rd%0d_after_err", k),    err[k],    1'b0);
    check($sformatf("rd%0d_after_dout", k),   dout[k],   exp_d);
  endtask

  task automatic reset_mid_read(input int k);
    check("rst_ready_before", ready[k], 1'b1);
    rd[k] = 1'b1; wr[k] = 1'b0; addr[k] = 3'd1;
    @(negedge clk);
    check("rst_in_wait", ready[k], 1'b0);
    drive_idle(k);
    rstn[k] = 1'b0;
    #1;
    clear_model(k);
    check("rst_async_ready",  ready[k],  1'b1);
    check("rst_async_rvalid", rvalid[k], 1'b0);
    check("rst_async_dout",   dout[k],   32'h0);
    check("rst_async_err",    err[k],    1'b0);
    for (int i = 0; i < RW[k] + 1; i++) begin
      @(negedge clk);
      check("rst_hold_rvalid", rvalid[k], 1'b0);
      check("rst_hold_ready",  ready[k],  1'b1);
    end
    rstn[k] = 1'b1;
    do_read(k, 3'd1);
    for (int a = 0; a < 8; a++) do_read(k, 3'(a));
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      rstn[k] = 1'b0;
      drive_idle(k);
      clear_model(k);
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      check($sformatf("reset%0d_ready", k),  ready[k],  1'b1);
      check($sformatf("reset%0d_rvalid", k), rvalid[k], 1'b0);
      check($sformatf("reset%0d_dout", k),   dout[k],   32'h0);
      check($sformatf("reset%0d_err", k),    err[k],    1'b0);
      rstn[k] = 1'b1;
    end
    @(negedge clk);

    // Full write then read on the RD_WAIT=1 instance.
    do_write(0, 3'd2, 32'hDEADBEEF, 4'hF, 1'b0);
    do_read (0, 3'd2);
    // Byte enables.
    do_write(0, 3'd1, 32'h11223344, 4'hF, 1'b0);
    do_write(0, 3'd1, 32'hAABBCCDD, 4'h5, 1'b0);
    do_read (0, 3'd1);
    check("be_merge_literal", m_regs[0][1], 32'h11BB33DD);
    // rd+wr collision is a write only.
    do_write(0, 3'd0, 32'h5, 4'hF, 1'b1);
    do_read (0, 3'd0);

    // Out-of-range on the NUM_REGS=5 instance.
    for (int a = 0; a < 5; a++) do_write(1, 3'(a), $urandom, 4'hF, 1'b0);
    do_write(1, 3'd6, 32'hFFFFFFFF, 4'hF, 1'b0);
    do_read (1, 3'd7);
    for (int a = 0; a < 5; a++) do_read(1, 3'(a));
    reset_mid_read(1);

    // Zero-wait read.
    do_write(2, 3'd4, 32'hCAFEF00D, 4'hF, 1'b0);
    do_read (2, 3'd4);

    // Randomised traffic on every instance.
    for (int k = 0; k < N; k++) begin
      for (int n = 0; n < 60; n++) begin
        case ($urandom_range(0, 3))
          0, 1:    do_write(k, 3'($urandom), $urandom, 4'($urandom), 1'b0);
          2:       do_read (k, 3'($urandom));
          default: do_write(k, 3'($urandom), $urandom, 4'($urandom), 1'b1);
        endcase
      end
      for (int a = 0; a < 8; a++) do_read(k, 3'(a));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
